led_pattern_ctrl: RTL
=====================

Name: led_pattern_ctrl

Overview:
- Button-driven controller for the board's 8-LED pattern engine.
- Three raw push-buttons are synchronised, debounced and turned into press events.
- Press events select the pattern mode, the step speed and pause/run.
- An internal step timer advances the selected pattern and drives the LED bank directly. The block replaces the fixed 1 s rotator at top level.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- DEBOUNCE_CYCLES, CLK_FREQ/100, consecutive stable cycles required to accept a button level change.
- STEP_BASE, CLK_FREQ/8, step period in cycles at the fastest speed.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- btn_mode  input  1  raw button, asynchronous, active-high.
- btn_speed  input  1  raw button, asynchronous, active-high.
- btn_pause  input  1  raw button, asynchronous, active-high.
- leds  output  8  LED pattern.
- mode  output  2  current mode: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 FILL.
- speed  output  2  current speed index.
- paused  output  1  high while stepping is halted.
- step_pulse  output  1  one-cycle pulse on every pattern step.

Behaviour:
- Reset (async assert, sync deassert into logic):
  - leds=8'h1F, mode=0, speed=0, paused=0, step_pulse=0.
  - Step counter=0, bounce dir=left, fill phase=fill.
  - Sync flops, debounced levels and debounce counters all 0.
  - Reset mid-operation aborts everything; no state survives.
- Input path, per button:
  - 2-FF synchroniser.
  - Debounce counter increments while synced level differs from debounced level, and clears on any cycle they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synced level and the counter clears.
  - Press event = one-cycle pulse on a debounced 0->1 transition. Releases generate nothing.
  - A button held through reset produces one press after debounce.
- Step timer:
  - Period P = STEP_BASE << (3-speed): speed 0 = 8x base (1 s at defaults), speed 3 = 1x base.
  - When paused==0, the counter counts 0..P-1. At P-1 it wraps to 0, step_pulse=1 for that cycle, and leds update on the same edge.
  - While paused, the counter holds its value. On resume it continues from the held count.
- Pattern steps:
  - ROT_L: leds <= {leds[6:0],leds[7]}.
  - ROT_R: leds <= {leds[0],leds[7:1]}.
  - BOUNCE: single-hot.
    - dir left: if leds==80, then dir<=right and leds<=40; else shift left.
    - dir right: if leds==01, then dir<=left and leds<=02; else shift right.
    - Cycle is 14 steps.
  - FILL, phase fill: if leds==FF, then phase<=drain and leds<=FE; else leds<={leds[6:0],1}.
  - FILL, phase drain: if leds==00, then phase<=fill and leds<=01; else leds<={leds[6:0],0}.
  - FILL cycle is 16 steps.
  - If a non-canonical value is present, the rules above still apply with no lockup.
- Mode press:
  - mode <= mode+1, wrapping 3->0.
  - Step counter cleared.
  - Seed loaded: ROT_L/ROT_R 1F; BOUNCE 01 with dir=left; FILL 00 with phase=fill.
  - paused unchanged.
- Speed press: speed <= speed+1, wrapping 3->0. Step counter cleared. leds unchanged.
- Pause press: paused toggles.
- Same-cycle events:
  - A mode press and a step in the same cycle: mode press wins. Seed is loaded, no step, step_pulse=0.
  - A speed press and a step in the same cycle: the step executes; the counter is then 0 under the new speed.
  - A pause press and a step in the same cycle: the step executes, because the pre-edge paused==0 governs.
  - Multiple presses in the same cycle are all applied.
- All outputs are registered.

Test Plan:
Common setup for all scenarios: CLK_FREQ=80, DEBOUNCE_CYCLES=4, STEP_BASE=10.
- Reset, no buttons:
  - leds=1F, mode=0, speed=0.
  - step_pulse every 80 cycles.
  - leds sequence 1F,3E,7C,F8,F1.
  - Mid-run rst_n low returns leds=1F immediately.
- Debounce:
  - A 3-cycle btn_mode glitch produces no mode change.
  - A held press changes mode to 1 within DEBOUNCE_CYCLES+2..+4 cycles of the edge.
  - Release produces no event.
- Mode walk:
  - 4 presses step mode 1,2,3,0 with seeds 1F,01,00,1F.
  - In ROT_R: 1F,8F,C7.
  - In BOUNCE: 01,02,..,80,40,..,01 (14 steps).
  - In FILL: 00,01,03,..,FF,FE,..,80,00 (16 steps).
- Speed: three speed presses give speed=3, with step_pulse spacing 80->40->20->10. A fourth press returns to 80.
- Pause:
  - Press pause at counter=30: no step_pulse and leds frozen for 500 cycles.
  - Press again: next step_pulse after 49 cycles.
- Collisions:
  - Mode press in the step cycle: seed loaded, no step_pulse.
  - Pause press in the step cycle: that step occurs, then paused=1.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: three debounced push-buttons select the pattern mode,
// the step speed and pause/run for the 8-LED pattern engine. An internal
// step timer advances the selected pattern and drives the LED bank.
module led_pattern_ctrl #(
    parameter int CLK_FREQ        = 25_000_000,
    parameter int DEBOUNCE_CYCLES = CLK_FREQ / 100,
    parameter int STEP_BASE       = CLK_FREQ / 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_speed,
    input  logic       btn_pause,
    output logic [7:0] leds,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       paused,
    output logic       step_pulse
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W = $clog2(8 * STEP_BASE + 1);

    localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_BASE = CNT_W'(STEP_BASE);

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    // ------------------------------------------------------------------
    // Reset: asserted asynchronously, released synchronously so every
    // flop below leaves reset on the same clock edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    // Two-stage reset release synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Button path: bit 0 = mode, bit 1 = speed, bit 2 = pause
    // ------------------------------------------------------------------
    logic [2:0] btn_raw;
    logic [2:0] press_evt;

    assign btn_raw = {btn_pause, btn_speed, btn_mode};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic            sync1_q;
            logic            sync2_q;
            logic            level_q;
            logic            level_d;
            logic            press_q;
            logic            press_d;
            logic [DB_W-1:0] db_cnt_q;
            logic [DB_W-1:0] db_cnt_d;

            // Debounce: accept a new level only after it has been stable
            // for DEBOUNCE_CYCLES cycles; flag a press on an accepted rise
            always_comb begin
                level_d  = level_q;
                press_d  = 1'b0;
                db_cnt_d = '0;
                if (sync2_q != level_q) begin
                    if (db_cnt_q == DB_LAST) begin
                        level_d = sync2_q;
                        press_d = sync2_q;
                    end else begin
                        db_cnt_d = db_cnt_q + DB_ONE;
                    end
                end
            end

            // Synchroniser, debounced level, counter and press pulse
            always_ff @(posedge clk or negedge rst_int_n) begin
                if (!rst_int_n) begin
                    sync1_q  <= 1'b0;
                    sync2_q  <= 1'b0;
                    level_q  <= 1'b0;
                    press_q  <= 1'b0;
                    db_cnt_q <= '0;
                end else begin
                    sync1_q  <= btn_raw[gi];
                    sync2_q  <= sync1_q;
                    level_q  <= level_d;
                    press_q  <= press_d;
                    db_cnt_q <= db_cnt_d;
                end
            end

            assign press_evt[gi] = press_q;
        end
    endgenerate

    logic mode_press;
    logic speed_press;
    logic pause_press;

    assign mode_press  = press_evt[0];
    assign speed_press = press_evt[1];
    assign pause_press = press_evt[2];

    // ------------------------------------------------------------------
    // Pattern engine state
    // ------------------------------------------------------------------
    mode_e            mode_q, mode_d;
    logic [1:0]       speed_q, speed_d;
    logic             paused_q, paused_d;
    logic             step_pulse_q, step_pulse_d;
    logic [7:0]       leds_q, leds_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;        // bounce: 0 = left, 1 = right
    logic             phase_q, phase_d;    // fill: 0 = fill, 1 = drain

    logic [CNT_W-1:0] period_last;
    logic             step;
    logic [7:0]       step_leds;
    logic             step_dir;
    logic             step_phase;

    // Period is STEP_BASE scaled by 8/4/2/1 for speed 0..3
    assign period_last = (CNT_BASE << (2'd3 - speed_q)) - CNT_ONE;
    assign step        = !paused_q && (cnt_q == period_last);

    // Next pattern value for the current mode
    always_comb begin
        step_leds  = leds_q;
        step_dir   = dir_q;
        step_phase = phase_q;
        unique case (mode_q)
            MODE_ROT_L: step_leds = {leds_q[6:0], leds_q[7]};
            MODE_ROT_R: step_leds = {leds_q[0], leds_q[7:1]};
            MODE_BOUNCE: begin
                if (!dir_q) begin
                    if (leds_q == 8'h80) begin
                        step_dir  = 1'b1;
                        step_leds = 8'h40;
                    end else begin
                        step_leds = {leds_q[6:0], 1'b0};
                    end
                end else begin
                    if (leds_q == 8'h01) begin
                        step_dir  = 1'b0;
                        step_leds = 8'h02;
                    end else begin
                        step_leds = {1'b0, leds_q[7:1]};
                    end
                end
            end
            MODE_FILL: begin
                if (!phase_q) begin
                    if (leds_q == 8'hFF) begin
                        step_phase = 1'b1;
                        step_leds  = 8'hFE;
                    end else begin
                        step_leds = {leds_q[6:0], 1'b1};
                    end
                end else begin
                    if (leds_q == 8'h00) begin
                        step_phase = 1'b0;
                        step_leds  = 8'h01;
                    end else begin
                        step_leds = {leds_q[6:0], 1'b0};
                    end
                end
            end
            default: ;
        endcase
    end

    // Next state: step timer, then button actions; a mode press overrides
    // a coincident step, speed/pause presses let it complete
    always_comb begin
        mode_d       = mode_q;
        speed_d      = speed_q;
        paused_d     = paused_q;
        step_pulse_d = 1'b0;
        leds_d       = leds_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        phase_d      = phase_q;

        if (!paused_q) begin
            cnt_d = step ? '0 : cnt_q + CNT_ONE;
        end

        if (step) begin
            leds_d       = step_leds;
            dir_d        = step_dir;
            phase_d      = step_phase;
            step_pulse_d = 1'b1;
        end

        if (speed_press) begin
            speed_d = speed_q + 2'd1;
            cnt_d   = '0;
        end

        if (pause_press) begin
            paused_d = !paused_q;
        end

        if (mode_press) begin
            mode_d       = mode_e'(mode_q + 2'd1);
            cnt_d        = '0;
            step_pulse_d = 1'b0;
            dir_d        = 1'b0;
            phase_d      = 1'b0;
            unique case (mode_d)
                MODE_BOUNCE: leds_d = 8'h01;
                MODE_FILL:   leds_d = 8'h00;
                default:     leds_d = 8'h1F;
            endcase
        end
    end

    // Pattern engine registers
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            mode_q       <= MODE_ROT_L;
            speed_q      <= 2'd0;
            paused_q     <= 1'b0;
            step_pulse_q <= 1'b0;
            leds_q       <= 8'h1F;
            cnt_q        <= '0;
            dir_q        <= 1'b0;
            phase_q      <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            speed_q      <= speed_d;
            paused_q     <= paused_d;
            step_pulse_q <= step_pulse_d;
            leds_q       <= leds_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            phase_q      <= phase_d;
        end
    end

    assign leds       = leds_q;
    assign mode       = mode_q;
    assign speed      = speed_q;
    assign paused     = paused_q;
    assign step_pulse = step_pulse_q;

endmodule
